id_hazard_scoreboard: RTL and testbench

//  Parametrised hazard/forwarding scoreboard for the decode stage; replaces fixed-depth EX/MEM/WB compare logic.

---
 rtl/id_hazard_scoreboard.sv | 168 ++++++++++++++++
 tb/tb_id_hazard_scoreboard.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage hazard/forwarding scoreboard: per-register in-flight write tracking by age and producer latency.
// Optional stall statistics counters are enabled with `define SB_STALL_STATS_EN.

module sb_entry #(
  parameter int PIPE_DEPTH = 3,
  parameter int SEL_W      = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic             i_flush,
  input  logic [SEL_W-1:0] i_lat,
  output logic             o_busy,
  output logic [SEL_W-1:0] o_age,
  output logic [SEL_W-1:0] o_lat
);
  logic             r_busy;
  logic [SEL_W-1:0] r_age;
  logic [SEL_W-1:0] r_lat;

  // A new write overrides aging of the older producer (youngest writer wins).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_age  <= '0;
      r_lat  <= '0;
    end else if (i_wr) begin
      r_busy <= 1'b1;
      r_age  <= SEL_W'(1);
      r_lat  <= i_lat;
    end else if (i_flush) begin
      r_busy <= 1'b0;
    end else if (r_busy) begin
      if (r_age == SEL_W'(PIPE_DEPTH)) r_busy <= 1'b0;
      else                             r_age  <= r_age + SEL_W'(1);
    end
  end

  assign o_busy = r_busy;
  assign o_age  = r_age;
  assign o_lat  = r_lat;
endmodule

module id_hazard_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int PIPE_DEPTH = 3,
  parameter int ALU_LAT    = 1,
  parameter int LD_LAT     = 2,
  parameter int MUL_LAT    = 3,
  localparam int IDX_W     = $clog2(NUM_REGS),
  localparam int SEL_W     = $clog2(PIPE_DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_issue_valid,
  input  logic             i_issue_reg_wr,
  input  logic [IDX_W-1:0] i_issue_dest_idx,
  input  logic [1:0]       i_issue_class,
  input  logic [IDX_W-1:0] i_ra_idx,
  input  logic [IDX_W-1:0] i_rb_idx,
  input  logic             i_ra_used,
  input  logic             i_rb_used,
  input  logic             i_flush,
  output logic [SEL_W-1:0] o_fwd_sel_a,
  output logic [SEL_W-1:0] o_fwd_sel_b,
  output logic             o_stall
`ifdef SB_STALL_STATS_EN
  ,
  output logic [31:0]      o_stall_cycles,
  output logic [31:0]      o_load_use_stalls
`endif
);
  typedef struct packed {
    logic             stall;
    logic [SEL_W-1:0] sel;
  } lookup_t;

  if (ALU_LAT < 1 || ALU_LAT > PIPE_DEPTH || LD_LAT < 1 || LD_LAT > PIPE_DEPTH ||
      MUL_LAT < 1 || MUL_LAT > PIPE_DEPTH) begin : g_bad_lat
    $error("id_hazard_scoreboard: every *_LAT must lie in 1..PIPE_DEPTH");
  end

  logic [NUM_REGS-1:0]            w_busy;
  logic [NUM_REGS-1:0][SEL_W-1:0] w_age;
  logic [NUM_REGS-1:0][SEL_W-1:0] w_lat;
  logic                           w_issue;
  logic [SEL_W-1:0]               w_cls_lat;
  lookup_t                        w_look_a, w_look_b;

  always_comb begin
    w_cls_lat = SEL_W'(MUL_LAT);
    case (i_issue_class)
      2'd0:    w_cls_lat = SEL_W'(ALU_LAT);
      2'd1:    w_cls_lat = SEL_W'(LD_LAT);
      default: w_cls_lat = SEL_W'(MUL_LAT);
    endcase
  end

  assign w_issue = i_issue_valid & ~o_stall & i_issue_reg_wr & (i_issue_dest_idx != '0) & ~i_flush;

  // x0 is hard-wired idle so lookups of it can never hit.
  assign w_busy[0] = 1'b0;
  assign w_age[0]  = '0;
  assign w_lat[0]  = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
    sb_entry #(.PIPE_DEPTH(PIPE_DEPTH), .SEL_W(SEL_W)) u_ent (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_wr    (w_issue && (i_issue_dest_idx == IDX_W'(r))),
      .i_flush (i_flush),
      .i_lat   (w_cls_lat),
      .o_busy  (w_busy[r]),
      .o_age   (w_age[r]),
      .o_lat   (w_lat[r])
    );
  end

  function automatic lookup_t lookup(input logic used, input logic [IDX_W-1:0] idx,
                                     input logic [NUM_REGS-1:0] busy,
                                     input logic [NUM_REGS-1:0][SEL_W-1:0] age,
                                     input logic [NUM_REGS-1:0][SEL_W-1:0] lat);
    lookup_t res;
    res = '0;
    if (used && idx != '0 && busy[idx]) begin
      if (age[idx] >= lat[idx]) res.sel   = age[idx];
      else                      res.stall = 1'b1;
    end
    return res;
  endfunction

  always_comb begin
    w_look_a = lookup(i_ra_used, i_ra_idx, w_busy, w_age, w_lat);
    w_look_b = lookup(i_rb_used, i_rb_idx, w_busy, w_age, w_lat);
  end

  assign o_fwd_sel_a = w_look_a.sel;
  assign o_fwd_sel_b = w_look_b.sel;
  assign o_stall     = w_look_a.stall | w_look_b.stall;

`ifdef SB_STALL_STATS_EN
  logic [NUM_REGS-1:0] r_is_ld;
  logic [31:0]         r_stall_cycles;
  logic [31:0]         r_load_use_stalls;
  logic                w_ld_block;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_is_ld <= '0;
    else if (w_issue) r_is_ld[i_issue_dest_idx] <= (i_issue_class == 2'd1);
  end

  assign w_ld_block = (w_look_a.stall & r_is_ld[i_ra_idx]) | (w_look_b.stall & r_is_ld[i_rb_idx]);

  // Counters saturate rather than wrap; flush does not touch them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cycles    <= '0;
      r_load_use_stalls <= '0;
    end else if (o_stall) begin
      if (r_stall_cycles != 32'hFFFF_FFFF)                   r_stall_cycles    <= r_stall_cycles + 32'd1;
      if (w_ld_block && r_load_use_stalls != 32'hFFFF_FFFF) r_load_use_stalls <= r_load_use_stalls + 32'd1;
    end
  end

  assign o_stall_cycles    = r_stall_cycles;
  assign o_load_use_stalls = r_load_use_stalls;
`endif
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Bench for id_hazard_scoreboard: issue-cycle based model checked every negedge plus directed literal checks.
module tb_id_hazard_scoreboard;
  localparam int PD = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_reg_wr, ra_used, rb_used, flush;
  logic [4:0] issue_dest_idx, ra_idx, rb_idx;
  logic [1:0] issue_class;
  logic [1:0] fwd_sel_a, fwd_sel_b;
  logic       stall;
`ifdef SB_STALL_STATS_EN
  logic [31:0] stall_cycles, load_use_stalls;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Model: the cycle each register's live write was accepted, plus its class.
  int cyc = 0;
  int m_iss[32];
  int m_cls[32];
  int m_sc = 0;
  int m_lu = 0;

  always #5 clk = ~clk;

  id_hazard_scoreboard dut (
    .i_clk(clk), .i_rst(rst),
    .i_issue_valid(issue_valid), .i_issue_reg_wr(issue_reg_wr),
    .i_issue_dest_idx(issue_dest_idx), .i_issue_class(issue_class),
    .i_ra_idx(ra_idx), .i_rb_idx(rb_idx), .i_ra_used(ra_used), .i_rb_used(rb_used),
    .i_flush(flush),
    .o_fwd_sel_a(fwd_sel_a), .o_fwd_sel_b(fwd_sel_b), .o_stall(stall)
`ifdef SB_STALL_STATS_EN
    , .o_stall_cycles(stall_cycles), .o_load_use_stalls(load_use_stalls)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  function automatic int cls_lat(input int c);
    return (c == 0) ? 1 : (c == 1) ? 2 : 3;
  endfunction

  function automatic void exp_op(input logic used, input logic [4:0] idx,
                                 output int sel, output bit st, output bit ld);
    int age;
    sel = 0; st = 0; ld = 0;
    if (used && idx != 0) begin
      age = cyc - m_iss[idx];
      if (age >= 1 && age <= PD) begin
        if (age >= cls_lat(m_cls[idx])) sel = age;
        else begin st = 1; ld = (m_cls[idx] == 1); end
      end
    end
  endfunction

  initial for (int i = 0; i < 32; i++) begin m_iss[i] = -100; m_cls[i] = 0; end

  always @(posedge clk) begin
    int sa, sb; bit ta, tb, la, lb;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_iss[i] = -100;
      m_sc = 0; m_lu = 0;
    end else begin
      exp_op(ra_used, ra_idx, sa, ta, la);
      exp_op(rb_used, rb_idx, sb, tb, lb);
      if (ta || tb) begin m_sc++; if (la || lb) m_lu++; end
      if (flush) for (int i = 0; i < 32; i++) m_iss[i] = -100;
      else if (issue_valid && !(ta || tb) && issue_reg_wr && issue_dest_idx != 0) begin
        m_iss[issue_dest_idx] = cyc;
        m_cls[issue_dest_idx] = int'(issue_class);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    int sa, sb; bit ta, tb, la, lb;
    if (rst) begin sa = 0; sb = 0; ta = 0; tb = 0; m_sc = 0; m_lu = 0; end
    else begin exp_op(ra_used, ra_idx, sa, ta, la); exp_op(rb_used, rb_idx, sb, tb, lb); end
    chk("model_sel_a", 32'(fwd_sel_a), 32'(sa));
    chk("model_sel_b", 32'(fwd_sel_b), 32'(sb));
    chk("model_stall", 32'(stall), 32'(ta || tb));
`ifdef SB_STALL_STATS_EN
    chk("model_stall_cycles", stall_cycles, 32'(m_sc));
    chk("model_load_use", load_use_stalls, 32'(m_lu));
`endif
  end

  task automatic idle();
    issue_valid = 0; issue_reg_wr = 0; issue_dest_idx = 0; issue_class = 0;
    ra_idx = 0; rb_idx = 0; ra_used = 0; rb_used = 0; flush = 0;
  endtask
  task automatic tick(); @(posedge clk); #1; idle(); endtask
  task automatic iss(input logic [1:0] c, input logic [4:0] d);
    issue_valid = 1; issue_reg_wr = 1; issue_class = c; issue_dest_idx = d;
  endtask
  task automatic src_a(input logic [4:0] i); ra_idx = i; ra_used = 1; endtask
  task automatic src_b(input logic [4:0] i, input logic u); rb_idx = i; rb_used = u; endtask
  task automatic look(input string nm, input int ea, input int eb, input int es);
    #3;
    chk({nm, "_sel_a"}, 32'(fwd_sel_a), 32'(ea));
    chk({nm, "_sel_b"}, 32'(fwd_sel_b), 32'(eb));
    chk({nm, "_stall"}, 32'(stall), 32'(es));
  endtask

  initial begin
    rst = 1; idle(); src_a(5); src_b(5, 1);
    look("reset", 0, 0, 0);
    @(posedge clk); @(posedge clk); #1; rst = 0;
    look("post_reset", 0, 0, 0);

    tick(); iss(0, 3);
    tick(); src_a(3); look("alu_age1", 1, 0, 0);
    tick(); src_a(3); look("alu_age2", 2, 0, 0);
    tick(); src_a(3); look("alu_wb", 3, 0, 0);
    tick(); src_a(3); look("alu_retired", 0, 0, 0);

    tick(); iss(1, 7);
    tick(); src_b(7, 1); look("lu_stall", 0, 0, 1);
    tick(); src_b(7, 1); look("lu_fwd", 0, 2, 0);
`ifdef SB_STALL_STATS_EN
    chk("lit_stall_cycles", stall_cycles, 32'd1);
    chk("lit_load_use", load_use_stalls, 32'd1);
`endif

    tick(); iss(2, 4);
    tick(); iss(0, 4);
    tick(); src_a(4); look("waw", 1, 0, 0);

    tick(); iss(0, 0);
    tick(); src_a(0); look("x0", 0, 0, 0);
    tick(); iss(1, 9);
    tick(); src_b(9, 0); look("unused", 0, 0, 0);

    tick(); iss(1, 2);
    tick(); iss(0, 6); flush = 1; look("flush_cyc", 0, 0, 0);
    tick(); src_a(2); src_b(6, 1); look("post_flush", 0, 0, 0);

    tick(); iss(1, 10);
    tick(); src_a(10); iss(0, 11); look("drop_stall", 0, 0, 1);
    tick(); src_a(11); look("dropped_issue", 0, 0, 0);

    tick(); iss(0, 13);
    tick(); iss(1, 14);
    tick(); src_a(13); src_b(14, 1); look("mixed", 2, 0, 1);

    tick(); iss(0, 12);
    tick(); src_a(12); look("pre_async_rst", 1, 0, 0);
    #2 rst = 1;
    #1 chk("async_rst_sel_a", 32'(fwd_sel_a), 32'd0);
    chk("async_rst_stall", 32'(stall), 32'd0);
    tick(); rst = 0; src_a(12); look("after_async_rst", 0, 0, 0);

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
